// File: rtl/alu_arbiter_if.sv
// Signal bundle shared by alu_arbiter, its two requesters (A, B) and the shared ALU.
// The err signal exists only when ALU_ARB_OPCHECK_EN is defined.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req_a;
  logic             req_b;
  logic [3:0]       ctrl_a;
  logic [3:0]       ctrl_b;
  logic [WIDTH-1:0] op1_a;
  logic [WIDTH-1:0] op2_a;
  logic [WIDTH-1:0] op1_b;
  logic [WIDTH-1:0] op2_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             busy;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
  logic             err;
`endif

  modport slave (
    input  req_a, req_b, ctrl_a, ctrl_b, op1_a, op2_a, op1_b, op2_b,
    input  alu_res, alu_zero,
    output gnt_a, gnt_b, done_a, done_b, result, result_zero, busy,
    output alu_ctrl, alu_in1, alu_in2
`ifdef ALU_ARB_OPCHECK_EN
    , output err
`endif
  );

  modport master (
    output req_a, req_b, ctrl_a, ctrl_b, op1_a, op2_a, op1_b, op2_b,
    output alu_res, alu_zero,
    input  gnt_a, gnt_b, done_a, done_b, result, result_zero, busy,
    input  alu_ctrl, alu_in1, alu_in2
`ifdef ALU_ARB_OPCHECK_EN
    , input err
`endif
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between requesters A and B (IDLE -> EXEC -> DONE).
// Optional feature macro ALU_ARB_OPCHECK_EN: illegal opcodes are zeroed and flagged on err.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             last_b;
  logic             serve_b;
  logic             bad_op;
  logic             pick_b;
  logic             op_ok;
  logic [3:0]       win_ctrl;
  logic [WIDTH-1:0] win_op1;
  logic [WIDTH-1:0] win_op2;

  // On a tie the requester not served last wins; last_b resets high so A takes the first tie.
  assign pick_b   = bus.req_b & (~bus.req_a | ~last_b);
  assign win_ctrl = pick_b ? bus.ctrl_b : bus.ctrl_a;
  assign win_op1  = pick_b ? bus.op1_b  : bus.op1_a;
  assign win_op2  = pick_b ? bus.op2_b  : bus.op2_a;

`ifdef ALU_ARB_OPCHECK_EN
  always_comb begin
    case (win_ctrl)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: op_ok = 1'b1;
      default:                             op_ok = 1'b0;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      last_b          <= 1'b1;
      serve_b         <= 1'b0;
      bad_op          <= 1'b0;
      bus.gnt_a       <= 1'b0;
      bus.gnt_b       <= 1'b0;
      bus.done_a      <= 1'b0;
      bus.done_b      <= 1'b0;
      bus.result      <= '0;
      bus.result_zero <= 1'b0;
      bus.busy        <= 1'b0;
      bus.alu_ctrl    <= 4'd0;
      bus.alu_in1     <= '0;
      bus.alu_in2     <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      bus.err         <= 1'b0;
`endif
    end else begin
      bus.gnt_a  <= 1'b0;
      bus.gnt_b  <= 1'b0;
      bus.done_a <= 1'b0;
      bus.done_b <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      bus.err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            bus.alu_ctrl <= op_ok ? win_ctrl : 4'd0;
            bus.alu_in1  <= win_op1;
            bus.alu_in2  <= win_op2;
            bad_op       <= ~op_ok;
            serve_b      <= pick_b;
            bus.gnt_a    <= ~pick_b;
            bus.gnt_b    <= pick_b;
            bus.busy     <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          // An illegal opcode reports a zero result regardless of what the ALU produced.
          bus.result      <= bad_op ? '0 : bus.alu_res;
          bus.result_zero <= bad_op ? 1'b1 : bus.alu_zero;
          bus.done_a      <= ~serve_b;
          bus.done_b      <= serve_b;
`ifdef ALU_ARB_OPCHECK_EN
          bus.err         <= bad_op;
`endif
          state           <= DONE;
        end
        DONE: begin
          last_b   <= serve_b;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model; honours ALU_ARB_OPCHECK_EN when defined.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return {{(W-1){1'b0}}, (a < b)};
      4'd12:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic bit legal_fn(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd6) || (c == 4'd7) || (c == 4'd12);
  endfunction

  // Opcode the arbiter should present to the ALU, and whether err should accompany done.
  function automatic logic [3:0] drive_ctrl(input logic [3:0] c);
`ifdef ALU_ARB_OPCHECK_EN
    return legal_fn(c) ? c : 4'd0;
`else
    return c;
`endif
  endfunction

  function automatic bit err_fn(input logic [3:0] c);
`ifdef ALU_ARB_OPCHECK_EN
    return !legal_fn(c);
`else
    return 1'b0;
`endif
  endfunction

  assign bus.alu_res  = alu_fn(bus.alu_ctrl, bus.alu_in1, bus.alu_in2);
  assign bus.alu_zero = (bus.alu_res == '0);

  task automatic set_a(input logic r, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.req_a = r; bus.ctrl_a = c; bus.op1_a = x; bus.op2_a = y;
  endtask

  task automatic set_b(input logic r, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.req_b = r; bus.ctrl_b = c; bus.op1_b = x; bus.op2_b = y;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_a(1'b0, 4'd0, '0, '0);
    set_b(1'b0, 4'd0, '0, '0);
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.result_zero} !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.result_zero}); end
    vectors++; if (bus.result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
    vectors++; if ({bus.alu_ctrl, bus.alu_in1, bus.alu_in2} !== '0) begin errors++; $display("[TB] FAIL reset_alu_drive: got %h %h %h expected 0", bus.alu_ctrl, bus.alu_in1, bus.alu_in2); end
`ifdef ALU_ARB_OPCHECK_EN
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
`endif
    reset = 1'b0;
    set_a(1'b1, 4'd2, 32'd5, 32'd7);
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.busy} !== 2'b11) begin errors++; $display("[TB] FAIL midexec_gnt: got gnt_a,busy=%b expected 11", {bus.gnt_a, bus.busy}); end
    // Reset lands asynchronously in the middle of the EXEC cycle.
    #2 reset = 1'b1;
    #1;
    vectors++; if ({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.result_zero} !== 6'b0) begin errors++; $display("[TB] FAIL midexec_flags: got %b expected 000000", {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.result_zero}); end
    vectors++; if ({bus.result, bus.alu_ctrl, bus.alu_in1, bus.alu_in2} !== '0) begin errors++; $display("[TB] FAIL midexec_data: got %h %h %h %h expected 0", bus.result, bus.alu_ctrl, bus.alu_in1, bus.alu_in2); end
    @(negedge clk);
    vectors++; if ({bus.done_a, bus.busy} !== 2'b00) begin errors++; $display("[TB] FAIL midexec_no_done: got done_a,busy=%b expected 00", {bus.done_a, bus.busy}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin errors++; $display("[TB] FAIL post_reset_gnt: got %b expected 10", {bus.gnt_a, bus.gnt_b}); end
    @(negedge clk);
    vectors++; if (bus.done_a !== 1'b1 || bus.result !== 32'd12) begin errors++; $display("[TB] FAIL post_reset_done: got done_a=%b result=%h expected 1 0000000c", bus.done_a, bus.result); end
    set_a(1'b0, 4'd0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_single_a();
    set_a(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.gnt_b, bus.done_a, bus.busy} !== 4'b1001) begin errors++; $display("[TB] FAIL single_gnt: got gnt_a,gnt_b,done_a,busy=%b expected 1001", {bus.gnt_a, bus.gnt_b, bus.done_a, bus.busy}); end
    vectors++; if ({bus.alu_ctrl, bus.alu_in1, bus.alu_in2} !== {4'd2, 32'hFFFF_FFFF, 32'd1}) begin errors++; $display("[TB] FAIL single_drive: got %h %h %h expected 2 ffffffff 00000001", bus.alu_ctrl, bus.alu_in1, bus.alu_in2); end
    @(negedge clk);
    vectors++; if ({bus.done_a, bus.gnt_a, bus.busy} !== 3'b101) begin errors++; $display("[TB] FAIL single_done: got done_a,gnt_a,busy=%b expected 101", {bus.done_a, bus.gnt_a, bus.busy}); end
    vectors++; if (bus.result !== '0 || bus.result_zero !== 1'b1) begin errors++; $display("[TB] FAIL single_result: got %h zero=%b expected 00000000 zero=1", bus.result, bus.result_zero); end
    set_a(1'b0, 4'd0, '0, '0);
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || bus.done_a !== 1'b0 || bus.result !== '0) begin errors++; $display("[TB] FAIL single_hold: got busy=%b done_a=%b result=%h expected 0 0 0", bus.busy, bus.done_a, bus.result); end
  endtask

  task automatic test_round_robin();
    bit exp_b = 1'b0;
    bit served_b = 1'b0;
    int grants = 0;
    int dones = 0;
    logic [W-1:0] exp_res;
    reset = 1'b1;
    set_a(1'b1, 4'd6, 32'd10, 32'd3);
    set_b(1'b1, 4'd7, 32'd2, 32'd9);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.gnt_a || bus.gnt_b) begin
        vectors++; if ({bus.gnt_a, bus.gnt_b} !== (exp_b ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL rr_order grant %0d: got %b expected %b", grants, {bus.gnt_a, bus.gnt_b}, exp_b ? 2'b01 : 2'b10); end
        served_b = bus.gnt_b;
        exp_b = !exp_b;
        grants++;
      end
      if (bus.done_a || bus.done_b) begin
        exp_res = served_b ? 32'd1 : 32'd7;
        vectors++; if ({bus.done_a, bus.done_b} !== (served_b ? 2'b01 : 2'b10) || bus.result !== exp_res) begin errors++; $display("[TB] FAIL rr_done %0d: got done=%b result=%h expected result %h", dones, {bus.done_a, bus.done_b}, bus.result, exp_res); end
        dones++;
      end
    end
    set_a(1'b0, 4'd0, '0, '0);
    set_b(1'b0, 4'd0, '0, '0);
    vectors++; if (grants !== 4 || dones !== 4) begin errors++; $display("[TB] FAIL rr_throughput: got %0d grants %0d dones expected 4 4", grants, dones); end
  endtask

  task automatic test_tie_after_b();
    set_b(1'b1, 4'd12, '0, '0);
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin errors++; $display("[TB] FAIL tie_b_gnt: got %b expected 01", {bus.gnt_a, bus.gnt_b}); end
    @(negedge clk);
    vectors++; if (bus.done_b !== 1'b1 || bus.result !== 32'hFFFF_FFFF || bus.result_zero !== 1'b0) begin errors++; $display("[TB] FAIL tie_b_nor: got done_b=%b result=%h zero=%b expected 1 ffffffff 0", bus.done_b, bus.result, bus.result_zero); end
    set_b(1'b0, 4'd0, '0, '0);
    @(negedge clk);
    set_a(1'b1, 4'd0, 32'hF0F0_1234, 32'hFF00_FF00);
    set_b(1'b1, 4'd1, 32'd1, 32'd2);
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin errors++; $display("[TB] FAIL tie_winner: got %b expected 10", {bus.gnt_a, bus.gnt_b}); end
    @(negedge clk);
    vectors++; if (bus.done_a !== 1'b1 || bus.result !== 32'hF000_1200) begin errors++; $display("[TB] FAIL tie_a_and: got done_a=%b result=%h expected 1 f0001200", bus.done_a, bus.result); end
    set_a(1'b0, 4'd0, '0, '0);
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.gnt_b, bus.busy} !== 3'b000) begin errors++; $display("[TB] FAIL tie_idle: got gnt,busy=%b expected 000", {bus.gnt_a, bus.gnt_b, bus.busy}); end
    @(negedge clk);
    vectors++; if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin errors++; $display("[TB] FAIL tie_loser_gnt: got %b expected 01", {bus.gnt_a, bus.gnt_b}); end
    @(negedge clk);
    vectors++; if (bus.done_b !== 1'b1 || bus.result !== 32'd3) begin errors++; $display("[TB] FAIL tie_b_or: got done_b=%b result=%h expected 1 00000003", bus.done_b, bus.result); end
    set_b(1'b0, 4'd0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_op_change();
    set_a(1'b1, 4'd2, 32'd100, 32'd23);
    @(negedge clk);
    vectors++; if (bus.gnt_a !== 1'b1) begin errors++; $display("[TB] FAIL chg_a_gnt: got %b expected 1", bus.gnt_a); end
    set_b(1'b1, 4'd6, 32'd1000, 32'd1);
    @(negedge clk);
    vectors++; if (bus.done_a !== 1'b1 || bus.result !== 32'd123) begin errors++; $display("[TB] FAIL chg_a_done: got done_a=%b result=%h expected 1 0000007b", bus.done_a, bus.result); end
    set_a(1'b0, 4'd0, '0, '0);
    bus.op1_b = 32'd2000;
    @(negedge clk);
    vectors++; if (bus.gnt_b !== 1'b0) begin errors++; $display("[TB] FAIL chg_early_gnt: got %b expected 0", bus.gnt_b); end
    bus.op1_b = 32'd3000;
    @(negedge clk);
    vectors++; if (bus.gnt_b !== 1'b1 || bus.alu_in1 !== 32'd3000) begin errors++; $display("[TB] FAIL chg_b_gnt: got gnt_b=%b alu_in1=%h expected 1 00000bb8", bus.gnt_b, bus.alu_in1); end
    @(negedge clk);
    vectors++; if (bus.done_b !== 1'b1 || bus.result !== 32'd2999) begin errors++; $display("[TB] FAIL chg_b_done: got done_b=%b result=%h expected 1 00000bb7", bus.done_b, bus.result); end
    set_b(1'b0, 4'd0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_bad_opcode();
    set_a(1'b1, 4'd5, 32'd3, 32'd4);
    @(negedge clk);
    vectors++; if (bus.gnt_a !== 1'b1 || bus.alu_ctrl !== drive_ctrl(4'd5)) begin errors++; $display("[TB] FAIL badop_gnt: got gnt_a=%b alu_ctrl=%h expected 1 %h", bus.gnt_a, bus.alu_ctrl, drive_ctrl(4'd5)); end
    @(negedge clk);
    vectors++; if (bus.done_a !== 1'b1 || bus.result !== '0 || bus.result_zero !== 1'b1) begin errors++; $display("[TB] FAIL badop_done: got done_a=%b result=%h zero=%b expected 1 0 1", bus.done_a, bus.result, bus.result_zero); end
`ifdef ALU_ARB_OPCHECK_EN
    vectors++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL badop_err: got %b expected 1", bus.err); end
`endif
    set_a(1'b0, 4'd0, '0, '0);
    @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL badop_err_pulse: got %b expected 0", bus.err); end
`endif
  endtask

  task automatic test_random();
    logic [3:0]   c_q [2];
    logic [W-1:0] x_q [2];
    logic [W-1:0] y_q [2];
    bit           pend [2];
    logic [3:0]   legal_ops [6];
    int exp_gnt = -1, exp_done = -1, inflight = -1, skip = 0, just_done, w;
    bit last_b = 1'b1;
    bit op_err = 1'b0;
    logic [3:0]   op_ctrl = '0;
    logic [W-1:0] op_x = '0, op_y = '0, op_res = '0, hold_res = '0;
    logic         op_z = 1'b0, hold_z = 1'b0;
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    for (int r = 0; r < 2; r++) begin c_q[r] = '0; x_q[r] = '0; y_q[r] = '0; pend[r] = 1'b0; end
    reset = 1'b1;
    set_a(1'b0, 4'd0, '0, '0);
    set_b(1'b0, 4'd0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      vectors++; if ({bus.gnt_a, bus.gnt_b} !== {exp_gnt == 0, exp_gnt == 1}) begin errors++; $display("[TB] FAIL rnd_gnt cyc %0d: got %b expected %b", cyc, {bus.gnt_a, bus.gnt_b}, {exp_gnt == 0, exp_gnt == 1}); end
      vectors++; if ({bus.done_a, bus.done_b} !== {exp_done == 0, exp_done == 1}) begin errors++; $display("[TB] FAIL rnd_done cyc %0d: got %b expected %b", cyc, {bus.done_a, bus.done_b}, {exp_done == 0, exp_done == 1}); end
      vectors++; if (bus.busy !== (exp_gnt >= 0 || exp_done >= 0)) begin errors++; $display("[TB] FAIL rnd_busy cyc %0d: got %b expected %b", cyc, bus.busy, (exp_gnt >= 0 || exp_done >= 0)); end
      vectors++; if ({bus.result, bus.result_zero} !== {hold_res, hold_z}) begin errors++; $display("[TB] FAIL rnd_result cyc %0d: got %h zero=%b expected %h zero=%b", cyc, bus.result, bus.result_zero, hold_res, hold_z); end
      if (exp_gnt >= 0) begin
        vectors++; if ({bus.alu_ctrl, bus.alu_in1, bus.alu_in2} !== {op_ctrl, op_x, op_y}) begin errors++; $display("[TB] FAIL rnd_drive cyc %0d: got %h %h %h expected %h %h %h", cyc, bus.alu_ctrl, bus.alu_in1, bus.alu_in2, op_ctrl, op_x, op_y); end
      end
`ifdef ALU_ARB_OPCHECK_EN
      vectors++; if (bus.err !== (exp_done >= 0 && op_err)) begin errors++; $display("[TB] FAIL rnd_err cyc %0d: got %b expected %b", cyc, bus.err, (exp_done >= 0 && op_err)); end
`endif
      just_done = exp_done;
      if (just_done >= 0) begin
        pend[just_done] = 1'b0;
        inflight = -1;
        last_b = (just_done == 1);
      end
      // Requesters raise new work, or reshuffle operands they are still waiting on.
      for (int r = 0; r < 2; r++) begin
        if ((!pend[r] && r != just_done && $urandom_range(0, 2) == 0) ||
            (pend[r] && r != inflight && $urandom_range(0, 3) == 0)) begin
          pend[r] = 1'b1;
          c_q[r] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 5)];
          x_q[r] = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
          y_q[r] = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
        end
      end
      set_a(pend[0], c_q[0], x_q[0], y_q[0]);
      set_b(pend[1], c_q[1], x_q[1], y_q[1]);
      exp_done = exp_gnt;
      if (exp_done >= 0) begin hold_res = op_res; hold_z = op_z; end
      exp_gnt = -1;
      // Each operation ties the arbiter up for three edges: accept, capture, return to idle.
      if (skip > 0) skip--;
      else if (pend[0] || pend[1]) begin
        w = (pend[0] && pend[1]) ? (last_b ? 0 : 1) : (pend[1] ? 1 : 0);
        exp_gnt = w;
        inflight = w;
        skip = 2;
        op_ctrl = drive_ctrl(c_q[w]);
        op_x = x_q[w];
        op_y = y_q[w];
        op_res = alu_fn(c_q[w], x_q[w], y_q[w]);
        op_z = (op_res == '0);
        op_err = err_fn(c_q[w]);
      end
    end
    set_a(1'b0, 4'd0, '0, '0);
    set_b(1'b0, 4'd0, '0, '0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    set_a(1'b0, 4'd0, '0, '0);
    set_b(1'b0, 4'd0, '0, '0);
    test_reset();
    test_single_a();
    test_round_robin();
    test_tie_after_b();
    test_op_change();
    test_bad_opcode();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
